// File: rtl/aes_dec_key_sched.sv
// AES-128 decryption key schedule: expands the cipher key forward to RK10, then emits RK10..RK0
// Latency: start at edge E -> first key (rk_round=10) valid after edge E+10; then 1 key/cycle
// Backpressure: rk_valid held with key/index stable while rk_ready=0; nothing depends on rk_ready combinationally
//
// Ports:
//   clk, arst          clock (rising edge), asynchronous active-low reset
//   start, key_in      begin a schedule with key_in (w0 in [127:96]); sampled only while idle
//   idle               high in IDLE
//   rk_valid/rk_ready  handshake for round_key_out and rk_round (10 down to 0)
//   done               one-cycle pulse after round key 0 is accepted
module aes_dec_key_sched #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         idle,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] round_key_out,
  output logic [3:0]   rk_round,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, FWD, REV} state_t;

  localparam logic [3:0] LAST = 4'(NR);

  state_t       state, state_nxt;
  logic [127:0] key_reg, key_nxt;
  logic [3:0]   cnt, cnt_nxt;
  logic         done_nxt;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sb_in, sub, rc, t0;
  logic [31:0]  f1, f2, f3;
  logic [127:0] fwd_key, inv_key;
  logic         hs;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box computed as multiplicative inverse (x^254, which maps 0 to 0)
  // followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = x;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  assign {w0, w1, w2, w3} = key_reg;

  // One shared S-box word: forward uses w3, inverse uses the recovered w3' = w3^w2.
  assign sb_in = (state == REV) ? (w3 ^ w2) : w3;
  // RotWord folded into the byte order of the S-box lanes.
  assign sub   = {sbox(sb_in[23:16]), sbox(sb_in[15:8]), sbox(sb_in[7:0]), sbox(sb_in[31:24])};
  assign rc    = {rcon(cnt), 24'h000000};
  // w0 ^ SubWord(RotWord(.)) ^ rcon is common to both directions.
  assign t0    = w0 ^ sub ^ rc;

  assign f1      = w1 ^ t0;
  assign f2      = w2 ^ f1;
  assign f3      = w3 ^ f2;
  assign fwd_key = {t0, f1, f2, f3};
  assign inv_key = {t0, w1 ^ w0, w2 ^ w1, w3 ^ w2};

  assign idle          = (state == IDLE);
  assign rk_valid      = (state == REV);
  assign round_key_out = key_reg;
  assign rk_round      = cnt;
  assign hs            = rk_valid & rk_ready;

  always_comb begin
    state_nxt = state;
    key_nxt   = key_reg;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          key_nxt   = key_in;
          cnt_nxt   = 4'd1;
          state_nxt = FWD;
        end
      end
      FWD: begin
        key_nxt = fwd_key;
        // On the last step cnt stays at NR, which is the first reverse index.
        if (cnt == LAST) state_nxt = REV;
        else             cnt_nxt   = cnt + 4'd1;
      end
      REV: begin
        if (hs) begin
          if (cnt == 4'd0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            key_nxt = inv_key;
            cnt_nxt = cnt - 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state   <= IDLE;
      key_reg <= 128'h0;
      cnt     <= 4'd0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      key_reg <= key_nxt;
      cnt     <= cnt_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Testbench for aes_dec_key_sched: scoreboard of expected reversed round keys
// built from an independent table-based forward expansion, compared on each handshake.
module tb_aes_dec_key_sched;

  logic         clk = 1'b0;
  logic         arst;
  logic         start;
  logic [127:0] key_in;
  logic         idle;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] round_key_out;
  logic [3:0]   rk_round;
  logic         done;

  always #5 clk = ~clk;

  aes_dec_key_sched #(.NR(10)) dut (
    .clk           (clk),
    .arst          (arst),
    .start         (start),
    .key_in        (key_in),
    .idle          (idle),
    .rk_valid      (rk_valid),
    .rk_ready      (rk_ready),
    .round_key_out (round_key_out),
    .rk_round      (rk_round),
    .done          (done)
  );

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [79:0] RCON = 80'h01020408102040801b36;

  localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;

  typedef struct packed {
    logic [3:0]   rnd;
    logic [127:0] key;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         mon_e;
  int           n_tests = 0;
  int           n_fail  = 0;
  int           hs_cnt  = 0;
  int           aborted;
  logic [127:0] exp_rk [0:10];
  logic [127:0] cap    [0:15];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  // Textbook forward expansion into w[0..43]; fills exp_rk[0..10].
  function automatic void expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
        t = t ^ {RCON[79 - 8*(i/4 - 1) -: 8], 24'h000000};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Monitor: every accepted key is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!arst) begin
      sb_q.delete();
    end else if (rk_valid && rk_ready) begin
      hs_cnt++;
      check("sb_nonempty", 128'(sb_q.size() != 0), 128'(1));
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check("rk_round", 128'(rk_round), 128'(mon_e.rnd));
        check("rk_key", round_key_out, mon_e.key);
      end
      cap[rk_round] = round_key_out;
    end
  end

  // Called at posedge+1 with idle expected high; returns at posedge(E)+1.
  task automatic start_sched(input logic [127:0] k);
    check("idle_before_start", 128'(idle), 128'(1));
    expand(k);
    for (int r = 10; r >= 0; r--) sb_q.push_back('{rnd: 4'(r), key: exp_rk[r]});
    key_in = k;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // mode 0: ready=1; 1: 5-cycle stall at round 7; 2: random ready;
  // 3: stray start pulses in FWD and REV; 4: reset at E+5; 5: reset at round 4.
  task automatic run(input int mode, input int budget, output int ab);
    int n = 0;
    int first_vld = -1;
    int vld_cycles = 0;
    int hs0 = hs_cnt;
    bit stalled = 0;
    bit rev_poked = 0;
    ab = 0;
    rk_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    while (n < budget) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      if (rk_valid) begin
        vld_cycles++;
        if (first_vld < 0) first_vld = n;
      end
      case (mode)
        1: if (!stalled && rk_valid && rk_round == 4'd7) begin
             stalled  = 1;
             rk_ready = 1'b0;
             for (int s = 0; s < 5; s++) begin
               @(posedge clk); #1;
               n++;
               check("stall_vld", 128'(rk_valid), 128'(1));
               check("stall_rnd", 128'(rk_round), 128'(7));
               check("stall_key", round_key_out, exp_rk[7]);
             end
             rk_ready = 1'b1;
           end
        2: rk_ready = 1'($urandom_range(0, 1));
        3: begin
             start = 1'b0;
             if (n == 3) begin
               check("ign_fwd_busy", 128'(idle), 128'(0));
               start  = 1'b1;
               key_in = ~key_in;
             end else if (!rev_poked && rk_valid && rk_round == 4'd5) begin
               rev_poked = 1;
               check("ign_rev_busy", 128'(idle), 128'(0));
               start  = 1'b1;
               key_in = KEY_SEQ;
             end
           end
        4: if (n == 5) begin
             arst = 1'b0;
             ab   = 1;
             break;
           end
        5: if (rk_valid && rk_round == 4'd4) begin
             arst = 1'b0;
             ab   = 1;
             break;
           end
        default: ;
      endcase
    end
    start = 1'b0;
    if (ab == 0) begin
      check("done_seen", 128'(done), 128'(1));
      check("latency", 128'(first_vld), 128'(10));
      check("hs_count", 128'(hs_cnt - hs0), 128'(11));
      check("sb_drained", 128'(sb_q.size()), 128'(0));
      check("idle_in_done", 128'(idle), 128'(1));
      if (mode == 0) check("vld_consecutive", 128'(vld_cycles), 128'(11));
    end
  endtask

  task automatic post_done();
    @(posedge clk); #1;
    check("done_one_cycle", 128'(done), 128'(0));
    check("idle_after", 128'(idle), 128'(1));
  endtask

  // arst is already low; outputs must be at reset values right away.
  task automatic reset_check(input string tag);
    #1;
    check({tag, "_idle"}, 128'(idle), 128'(1));
    check({tag, "_vld"}, 128'(rk_valid), 128'(0));
    check({tag, "_rnd"}, 128'(rk_round), 128'(0));
    check({tag, "_key"}, round_key_out, 128'h0);
    check({tag, "_done"}, 128'(done), 128'(0));
    @(posedge clk);
    @(posedge clk); #1;
    arst     = 1'b1;
    rk_ready = 1'b1;
  endtask

  initial begin
    arst     = 1'b0;
    start    = 1'b0;
    rk_ready = 1'b0;
    key_in   = 128'h0;
    #2;
    reset_check("por");

    // FIPS-197 known answers, full-rate consumer.
    start_sched(KEY_FIPS);
    run(0, 200, aborted);
    check("fips_rk10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("fips_rk1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_rk0", cap[0], KEY_FIPS);
    post_done();

    // Backpressure at round 7.
    start_sched(KEY_FIPS);
    run(1, 200, aborted);
    post_done();

    // Stray start while busy.
    start_sched(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
    run(3, 200, aborted);
    post_done();

    // Reset during FWD, then a clean run.
    start_sched(128'hdeadbeef0123456789abcdeffedcba98);
    run(4, 200, aborted);
    check("abort_fwd", 128'(aborted), 128'(1));
    reset_check("rst_fwd");
    start_sched(128'hdeadbeef0123456789abcdeffedcba98);
    run(0, 200, aborted);
    post_done();

    // Reset during REV at round 4, then a clean run.
    start_sched(128'h00112233445566778899aabbccddeeff);
    run(5, 200, aborted);
    check("abort_rev", 128'(aborted), 128'(1));
    reset_check("rst_rev");
    start_sched(128'h00112233445566778899aabbccddeeff);
    run(2, 400, aborted);
    post_done();

    // Back-to-back: start in the done cycle.
    start_sched(KEY_FIPS);
    run(0, 200, aborted);
    start_sched(KEY_SEQ);
    check("b2b_done_drop", 128'(done), 128'(0));
    run(0, 200, aborted);
    check("seq_rk10", cap[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("seq_rk0", cap[0], KEY_SEQ);
    post_done();

    // Random keys with random consumer.
    for (int k = 0; k < 4; k++) begin
      start_sched({$urandom, $urandom, $urandom, $urandom});
      run(2, 400, aborted);
      post_done();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
